uart_rx_ovs: RTL and testbench

UART_RX_OVS -- requirements
Module: uart_rx_ovs

---
 rtl/uart_rx_ovs.sv | 156 +++++++++++++++
 tb/tb_uart_rx_ovs.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_ovs.sv
// 16x oversampling UART receiver with 2-of-3 majority bit decisions and a
// one-word ready/valid output holding register. Optional parity via UART_RX_PARITY_EN.
module uart_rx_ovs #(
    parameter int CLK_DIV   = 27,
    parameter int DATA_BITS = 8,
    parameter int STOP_BITS = 1
`ifdef UART_RX_PARITY_EN
    , parameter bit PARITY_ODD = 1'b0
`endif
) (
    input  logic                 sys_clk,
    input  logic                 sys_rstn,
    input  logic                 rs232_rx,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 rx_frame_err,
    output logic                 rx_parity_err,
    output logic                 rx_overrun,
    output logic                 rx_busy
);

`ifdef UART_RX_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
    typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

    localparam logic [15:0] DIV_MAX   = 16'(CLK_DIV - 1);
    localparam logic [3:0]  LAST_DATA = 4'(DATA_BITS - 1);
    localparam logic [3:0]  LAST_STOP = 4'(STOP_BITS - 1);

    state_t                 state, next_state;
    logic                   rx_meta, rx_sync, rx_prev;
    logic [15:0]            div_cnt;
    logic [3:0]             smp, bit_cnt;
    logic                   s7, s8, maj, tick, done;
    logic                   ferr;
    logic [DATA_BITS-1:0]   shreg;

    assign tick    = (state != IDLE) && (div_cnt == DIV_MAX);
    assign maj     = (s7 & s8) | (s7 & rx_sync) | (s8 & rx_sync);
    assign rx_busy = (state != IDLE);

    always_ff @(posedge sys_clk or negedge sys_rstn) begin
        if (!sys_rstn) state <= IDLE;
        else           state <= next_state;
    end

    always_comb begin
        next_state = state;
        done       = 1'b0;
        case (state)
            IDLE:  if (rx_prev && !rx_sync) next_state = START;
            START: begin
                // Start bit that is not low at mid-bit is treated as line noise.
                if (tick && smp == 4'd9 && maj)  next_state = IDLE;
                else if (tick && smp == 4'd15)   next_state = DATA;
            end
            DATA:
                if (tick && smp == 4'd15 && bit_cnt == LAST_DATA)
`ifdef UART_RX_PARITY_EN
                    next_state = PARITY;
`else
                    next_state = STOP;
`endif
`ifdef UART_RX_PARITY_EN
            PARITY: if (tick && smp == 4'd15) next_state = STOP;
`endif
            STOP: begin
                // Finish at mid stop bit so a start edge right after it is caught.
                if (tick && smp == 4'd9 && bit_cnt == LAST_STOP) begin
                    next_state = IDLE;
                    done       = 1'b1;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge sys_clk or negedge sys_rstn) begin
        if (!sys_rstn) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
            rx_prev <= 1'b1;
            div_cnt <= '0;
            smp     <= '0;
            bit_cnt <= '0;
            s7      <= 1'b1;
            s8      <= 1'b1;
            ferr    <= 1'b0;
            shreg   <= '0;
        end else begin
            rx_meta <= rs232_rx;
            rx_sync <= rx_meta;
            rx_prev <= rx_sync;
            if (state == IDLE || tick) div_cnt <= '0;
            else                       div_cnt <= div_cnt + 16'd1;
            if (state == IDLE) begin
                smp     <= '0;
                bit_cnt <= '0;
                ferr    <= 1'b0;
            end else if (tick) begin
                smp <= smp + 4'd1;
                if (smp == 4'd7) s7 <= rx_sync;
                if (smp == 4'd8) s8 <= rx_sync;
                if (smp == 4'd9 && state == DATA) shreg <= {maj, shreg[DATA_BITS-1:1]};
                if (smp == 4'd9 && state == STOP && !maj) ferr <= 1'b1;
                if (smp == 4'd15 && (state == DATA || state == STOP))
                    bit_cnt <= (state == DATA && bit_cnt == LAST_DATA) ? 4'd0 : bit_cnt + 4'd1;
            end
        end
    end

`ifdef UART_RX_PARITY_EN
    logic perr;

    always_ff @(posedge sys_clk or negedge sys_rstn) begin
        if (!sys_rstn)                                  perr <= 1'b0;
        else if (tick && smp == 4'd9 && state == PARITY) perr <= ((^shreg) ^ maj) != PARITY_ODD;
    end
`endif

    always_ff @(posedge sys_clk or negedge sys_rstn) begin
        if (!sys_rstn) begin
            rx_data      <= '0;
            rx_valid     <= 1'b0;
            rx_frame_err <= 1'b0;
            rx_overrun   <= 1'b0;
`ifdef UART_RX_PARITY_EN
            rx_parity_err <= 1'b0;
`endif
        end else begin
            rx_overrun <= 1'b0;
            if (done) begin
                if (!rx_valid || rx_ready) begin
                    rx_data      <= shreg;
                    rx_frame_err <= ferr | ~maj;
                    rx_valid     <= 1'b1;
`ifdef UART_RX_PARITY_EN
                    rx_parity_err <= perr;
`endif
                end else begin
                    rx_overrun <= 1'b1;
                end
            end else if (rx_valid && rx_ready) begin
                rx_valid <= 1'b0;
            end
        end
    end

`ifndef UART_RX_PARITY_EN
    assign rx_parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_ovs.sv
// Scoreboard bench for uart_rx_ovs at CLK_DIV=4 (64 clocks per bit), 8 data bits.
module tb_uart_rx_ovs;

    typedef struct packed {
        logic [7:0] data;
        logic       ferr;
        logic       perr;
    } exp_t;

    logic       sys_clk = 1'b0;
    logic       sys_rstn = 1'b0;
    logic       rs232_rx = 1'b1;
    logic       rx_ready = 1'b1;
    logic [7:0] rx_data;
    logic       rx_valid, rx_frame_err, rx_parity_err, rx_overrun, rx_busy;

    int   checks = 0;
    int   errors = 0;
    int   valid_cnt = 0;
    int   ovr_cnt = 0;
    exp_t sb[$];

    uart_rx_ovs #(.CLK_DIV(4), .DATA_BITS(8), .STOP_BITS(1)) dut (
        .sys_clk(sys_clk), .sys_rstn(sys_rstn), .rs232_rx(rs232_rx),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
        .rx_frame_err(rx_frame_err), .rx_parity_err(rx_parity_err),
        .rx_overrun(rx_overrun), .rx_busy(rx_busy)
    );

    always #5 sys_clk = ~sys_clk;

    // Every accepted word is compared with the oldest expected entry.
    always @(negedge sys_clk) begin
        if (sys_rstn) begin
            if (rx_valid)   valid_cnt++;
            if (rx_overrun) ovr_cnt++;
            if (rx_valid && rx_ready) begin
                exp_t e;
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_word: got data=%h ferr=%b perr=%b, expected no word",
                             rx_data, rx_frame_err, rx_parity_err);
                end else begin
                    e = sb.pop_front();
                    if ({rx_data, rx_frame_err, rx_parity_err} !== {e.data, e.ferr, e.perr}) begin
                        errors++;
                        $display("FAIL word: got data=%h ferr=%b perr=%b, expected data=%h ferr=%b perr=%b",
                                 rx_data, rx_frame_err, rx_parity_err, e.data, e.ferr, e.perr);
                    end
                end
            end
        end
    end

    task automatic send_bit(input logic b);
        rs232_rx = b;
        repeat (64) @(negedge sys_clk);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop_v, input logic par_en,
                              input logic par_v, input int gap);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i]);
        if (par_en) send_bit(par_v);
        send_bit(stop_v);
        rs232_rx = 1'b1;
        repeat (gap) @(negedge sys_clk);
    endtask

    task automatic drain(output bit ok);
        int n = 0;
        while (sb.size() != 0 && n < 2000) begin
            @(negedge sys_clk);
            n++;
        end
        ok = (sb.size() == 0);
        sb.delete();
    endtask

    task automatic test_reset;
        sys_rstn = 1'b0;
        repeat (3) @(negedge sys_clk);
        checks++;
        if ({rx_valid, rx_busy, rx_overrun, rx_frame_err, rx_parity_err} !== 5'b0) begin
            errors++;
            $display("FAIL reset_flags: got %b, expected 00000",
                     {rx_valid, rx_busy, rx_overrun, rx_frame_err, rx_parity_err});
        end
        checks++;
        if (rx_data !== 8'h00) begin
            errors++;
            $display("FAIL reset_data: got %h, expected 00", rx_data);
        end
        sys_rstn = 1'b1;
        repeat (10) @(negedge sys_clk);
    endtask

    task automatic test_basic;
        bit ok;
        int v0;
        rx_ready = 1'b1;
        v0 = valid_cnt;
        sb.push_back('{data: 8'hA5, ferr: 1'b0, perr: 1'b0});
        send_frame(8'hA5, 1'b1, 1'b0, 1'b0, 64);
        drain(ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL basic_deliver: got no word, expected A5");
        end
        checks++;
        if (valid_cnt - v0 !== 1) begin
            errors++;
            $display("FAIL basic_valid_len: got %0d cycles, expected 1", valid_cnt - v0);
        end
        checks++;
        if (rx_busy !== 1'b0) begin
            errors++;
            $display("FAIL basic_idle: got busy=%b, expected 0", rx_busy);
        end
    endtask

    task automatic test_frame_err;
        bit ok;
        sb.push_back('{data: 8'h3C, ferr: 1'b1, perr: 1'b0});
        send_frame(8'h3C, 1'b0, 1'b0, 1'b0, 64);
        drain(ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL frame_err_deliver: got no word, expected 3C with ferr");
        end
        sb.push_back('{data: 8'h55, ferr: 1'b0, perr: 1'b0});
        send_frame(8'h55, 1'b1, 1'b0, 1'b0, 64);
        drain(ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL frame_err_recover: got no word, expected 55");
        end
    endtask

    task automatic test_glitch;
        int  v0;
        bit  saw_busy = 0;
        bit  idle_again = 0;
        v0 = valid_cnt;
        rs232_rx = 1'b0;
        repeat (20) begin
            @(negedge sys_clk);
            if (rx_busy) saw_busy = 1;
        end
        rs232_rx = 1'b1;
        for (int n = 0; n < 70 && !idle_again; n++) begin
            @(negedge sys_clk);
            if (rx_busy) saw_busy = 1;
            else if (saw_busy) idle_again = 1;
        end
        checks++;
        if (!(saw_busy && idle_again)) begin
            errors++;
            $display("FAIL glitch_busy: got saw_busy=%b idle_again=%b, expected 1 1", saw_busy, idle_again);
        end
        repeat (100) @(negedge sys_clk);
        checks++;
        if (valid_cnt !== v0) begin
            errors++;
            $display("FAIL glitch_no_word: got %0d valid cycles, expected 0", valid_cnt - v0);
        end
    endtask

    task automatic test_back_to_back;
        bit ok;
        int o0;
        o0 = ovr_cnt;
        rx_ready = 1'b0;
        sb.push_back('{data: 8'h11, ferr: 1'b0, perr: 1'b0});
        send_frame(8'h11, 1'b1, 1'b0, 1'b0, 0);
        send_frame(8'h22, 1'b1, 1'b0, 1'b0, 64);
        checks++;
        if ({rx_valid, rx_data} !== {1'b1, 8'h11}) begin
            errors++;
            $display("FAIL overrun_hold: got valid=%b data=%h, expected 1 11", rx_valid, rx_data);
        end
        checks++;
        if (ovr_cnt - o0 !== 1) begin
            errors++;
            $display("FAIL overrun_pulse: got %0d pulses, expected 1", ovr_cnt - o0);
        end
        rx_ready = 1'b1;
        drain(ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL overrun_release: got no word, expected 11");
        end
        repeat (5) @(negedge sys_clk);
        checks++;
        if (rx_valid !== 1'b0) begin
            errors++;
            $display("FAIL overrun_clear: got valid=%b, expected 0", rx_valid);
        end
    endtask

`ifdef UART_RX_PARITY_EN
    task automatic test_parity;
        bit ok;
        sb.push_back('{data: 8'h07, ferr: 1'b0, perr: 1'b1});
        send_frame(8'h07, 1'b1, 1'b1, 1'b0, 64);
        drain(ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL parity_bad: got no word, expected 07 with perr");
        end
        sb.push_back('{data: 8'h07, ferr: 1'b0, perr: 1'b0});
        send_frame(8'h07, 1'b1, 1'b1, 1'b1, 64);
        drain(ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL parity_good: got no word, expected 07 clean");
        end
    endtask
`endif

    task automatic test_reset_mid;
        bit ok;
        // Make sure outputs hold a word so an asynchronous clear is visible.
        rx_ready = 1'b0;
        sb.push_back('{data: 8'hC3, ferr: 1'b0, perr: 1'b0});
        send_frame(8'hC3, 1'b1, 1'b0, 1'b0, 32);
        send_bit(1'b0);
        for (int i = 0; i < 3; i++) send_bit(1'b1);
        checks++;
        if ({rx_busy, rx_valid} !== 2'b11) begin
            errors++;
            $display("FAIL mid_busy: got busy=%b valid=%b, expected 1 1", rx_busy, rx_valid);
        end
        #3 sys_rstn = 1'b0;
        #1;
        checks++;
        if ({rx_valid, rx_busy, rx_overrun, rx_frame_err, rx_parity_err, rx_data} !== 13'b0) begin
            errors++;
            $display("FAIL mid_reset: got valid=%b busy=%b data=%h, expected all 0", rx_valid, rx_busy, rx_data);
        end
        sb.delete();
        rx_ready = 1'b1;
        rs232_rx = 1'b1;
        repeat (10) @(negedge sys_clk);
        sys_rstn = 1'b1;
        repeat (20) @(negedge sys_clk);
        sb.push_back('{data: 8'h81, ferr: 1'b0, perr: 1'b0});
        send_frame(8'h81, 1'b1, 1'b0, 1'b0, 64);
        drain(ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL mid_recover: got no word, expected 81");
        end
    endtask

    initial begin
        test_reset;
        test_basic;
        test_frame_err;
        test_glitch;
        test_back_to_back;
`ifdef UART_RX_PARITY_EN
        test_parity;
`endif
        test_reset_mid;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
